idma_burst_gen: RTL
===================

# idma_burst_gen

Upstream burst generator of the iDMA AXI master path. Accepts one DMA transfer command (32-byte-aligned start address, total beat count), chops it into INCR bursts of at most 16 beats of 32 bytes, and presents them one at a time to the 4 KB-split stage on the `dma_trans_burst_*` interface. It tracks outstanding bursts against per-burst data completion, throttles issue at a fixed limit, and pulses `cmd_done` when all data of the command has completed.

## Interface
- `MAX_OUT`, 4: maximum bursts issued but not yet data-complete; legal range 1..15.
- `BEATW`, 16: width of the total beat count in a command.

- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: transfer command valid.
- `cmd_ready` out 1: block can accept a command.
- `cmd_addr` in 32: start byte address. Bits [4:0] are ignored and treated as 0.
- `cmd_beats` in BEATW: total 32-byte beats. 0 is legal.
- `cfg_max_len` in 4: maximum burst len minus 1. Sampled at command accept.
- `dma_trans_burst_avalid` out 1: burst request valid.
- `dma_trans_burst_addr` out 32: burst start address.
- `dma_trans_burst_len` out 4: burst beats minus 1.
- `dma_xaddr_burst_ok` in 1: downstream accepted the burst. This is one pulse per burst, including bursts it splits at 4 KB.
- `burst_data_done` in 1: pulse meaning data of one issued burst is complete.
- `cmd_done` out 1: one-cycle pulse when a command has fully completed.
- `outstanding` out clog2(MAX_OUT+1): count of bursts issued but not yet data-complete.
- `err_underflow` out 1: sticky. Set when `burst_data_done` arrives with `outstanding`==0.

## Operation
- Registers:
  - `cur_addr[31:0]`, `remain[BEATW-1:0]`, `max_len[3:0]`, `outstanding`.
  - FSM states: IDLE, ISSUE, DRAIN.
- Burst length: `dma_trans_burst_len` = (`remain` > `max_len`) ? `max_len` : `remain`-1, truncated to 4 bits. It is combinational from registers only.
- `dma_trans_burst_addr` = `cur_addr`.
- IDLE:
  - `cmd_ready`=1. `dma_trans_burst_avalid`=0.
  - On `cmd_valid`: load `cur_addr`={`cmd_addr`[31:5],5'b0}, `remain`=`cmd_beats`, `max_len`=`cfg_max_len`.
  - If `cmd_beats`!=0, go to ISSUE. Otherwise go to DRAIN.
- ISSUE:
  - `cmd_ready`=0. `dma_trans_burst_avalid` = (`outstanding` < MAX_OUT).
  - On `dma_xaddr_burst_ok`:
    - `cur_addr` += (len+1)<<5. The addition is modulo 2^32; no error on wrap.
    - `remain` -= len+1.
  - If `remain` equals len+1 at the `dma_xaddr_burst_ok`, go to DRAIN.
- DRAIN:
  - `cmd_ready`=0, `avalid`=0.
  - When next-`outstanding`==0, go to IDLE and register `cmd_done`=1 for the following cycle.
- `outstanding` update, each cycle:
  - +1 on `dma_xaddr_burst_ok`.
  - -1 on `burst_data_done` when `outstanding`>0.
  - Both in the same cycle: no change.
  - `burst_data_done` with `outstanding`==0 and no simultaneous `dma_xaddr_burst_ok`: count stays 0 and `err_underflow` sets. It clears only on reset.
- `dma_xaddr_burst_ok` while `avalid`=0 is a protocol violation. The block ignores it and does not update any register.
- `outstanding` is not cleared between commands. `burst_data_done` for a previous command may still arrive in IDLE of the next command.

## Timing
- Reset values:
  - `cmd_ready`=1, `dma_trans_burst_avalid`=0, `dma_trans_burst_addr`=0, `dma_trans_burst_len`=0.
  - `cmd_done`=0, `outstanding`=0, `err_underflow`=0, state IDLE.
- Reset mid-command aborts all state immediately. No `cmd_done` is produced.
- Command accept to first `avalid`: 1 cycle.
- After `dma_xaddr_burst_ok`, the next burst's `avalid`, `addr` and `len` are valid the next cycle. This gives back-to-back bursts, one per cycle maximum.
- While `avalid`=1 and no ok arrives, `addr` and `len` hold stable.
- `avalid` may drop only because `outstanding` reached MAX_OUT. It reasserts the cycle after `outstanding` falls below MAX_OUT.
- `cmd_done` timing:
  - Asserts in the first IDLE cycle after DRAIN.
  - A new command is acceptable in that same cycle.
  - For `cmd_beats`=0, `cmd_done` comes 2 cycles after accept.
- Combinational paths: `avalid` depends only on registers. No combinational path from `dma_xaddr_burst_ok` or `burst_data_done` to any output.

## Test plan
- Split into three bursts:
  - Stimulus: `cmd_addr`=0x1000_0000, `cmd_beats`=40, `cfg_max_len`=15, ok returned immediately.
  - Required: bursts (0x1000_0000,15), (0x1000_0200,15), (0x1000_0400,7).
  - Then three `burst_data_done` pulses, then `cmd_done` one cycle after the last one.
- Short max_len with remainder:
  - Stimulus: `cfg_max_len`=3, `cmd_beats`=5, `cmd_addr`=0x0000_0FE0.
  - Required: bursts (0x0FE0,3), (0x1060,0).
- Outstanding throttle:
  - Stimulus: MAX_OUT=4, `cmd_beats`=100, `cfg_max_len`=15, no data_done.
  - Required: exactly 4 bursts issue, then `avalid`=0 and `outstanding`=4.
  - One `burst_data_done` -> `avalid`=1 the next cycle with addr base+0x800.
- Zero-beat command:
  - Stimulus: `cmd_beats`=0.
  - Required: `avalid` never asserts, `cmd_done` 2 cycles after accept.
- Simultaneous events and underflow:
  - Stimulus 1: `dma_xaddr_burst_ok` and `burst_data_done` in the same cycle with `outstanding`=2. Required: stays 2.
  - Stimulus 2: `burst_data_done` at 0. Required: `err_underflow`=1 and `outstanding` stays 0.
- Reset and address wrap:
  - Stimulus 1: assert `aresetn`=0 mid-ISSUE. Required: all outputs return to reset values and no `cmd_done`.
  - Stimulus 2: `cmd_addr`=0xFFFF_FFE0, `cmd_beats`=2, `cfg_max_len`=0. Required: second burst addr 0x0000_0000.

Source files
------------

// File: rtl/idma_burst_gen.sv
// idma_burst_gen: chops one DMA transfer command into INCR bursts of at most
// 16 x 32-byte beats, issues them one at a time to the 4 KB-split stage, and
// tracks bursts issued but not yet data-complete against a fixed limit.
module idma_burst_gen #(
   parameter  int unsigned MAX_OUT = 4,
   parameter  int unsigned BEATW   = 16,
   localparam int unsigned OUTW    = $clog2(MAX_OUT + 1)
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_addr,
   input  logic [BEATW-1:0] cmd_beats,
   input  logic [3:0]       cfg_max_len,
   output logic             dma_trans_burst_avalid,
   output logic [31:0]      dma_trans_burst_addr,
   output logic [3:0]       dma_trans_burst_len,
   input  logic             dma_xaddr_burst_ok,
   input  logic             burst_data_done,
   output logic             cmd_done,
   output logic [OUTW-1:0]  outstanding,
   output logic             err_underflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      cur_addr;
   logic [BEATW-1:0] remain;
   logic [3:0]       max_len;
   logic [3:0]       len;
   logic [BEATW-1:0] burst_beats;
   logic [4:0]       burst_beats5;
   logic             issue_ok;
   logic             ok_acc;
   logic             load;
   logic [OUTW-1:0]  out_nxt;
   logic             underflow;

   // Current burst length from registered state only; an empty remain
   // (idle/after reset) reports 0 instead of the wrapped remain-1.
   always_comb begin
      len = '0;
      if (remain == '0) begin
         len = '0;
      end else if (remain > BEATW'(max_len)) begin
         len = max_len;
      end else begin
         len = 4'(remain - BEATW'(1));
      end
   end

   assign burst_beats5 = {1'b0, len} + 5'd1;
   assign burst_beats  = BEATW'(burst_beats5);

   // Issue is gated only by registered state; an ok while not valid is ignored.
   assign issue_ok = (state == S_ISSUE) && (outstanding < OUTW'(MAX_OUT));
   assign ok_acc   = issue_ok && dma_xaddr_burst_ok;

   assign dma_trans_burst_avalid = issue_ok;
   assign dma_trans_burst_addr   = cur_addr;
   assign dma_trans_burst_len    = len;

   // Next outstanding count: simultaneous issue and completion cancel out.
   always_comb begin
      out_nxt   = outstanding;
      underflow = 1'b0;
      if (ok_acc && burst_data_done) begin
         out_nxt = outstanding;
      end else if (ok_acc) begin
         out_nxt = outstanding + OUTW'(1);
      end else if (burst_data_done) begin
         if (outstanding != '0) begin
            out_nxt = outstanding - OUTW'(1);
         end else begin
            underflow = 1'b1;
         end
      end
   end

   // Next-state and command handshake decode.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load      = 1'b1;
               state_nxt = (cmd_beats != '0) ? S_ISSUE : S_DRAIN;
            end
         end
         S_ISSUE: begin
            if (ok_acc && (remain == burst_beats)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_nxt == '0) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command registers: load on accept, advance on each accepted burst.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cur_addr <= '0;
         remain   <= '0;
         max_len  <= '0;
      end else if (load) begin
         cur_addr <= {cmd_addr[31:5], 5'b0};
         remain   <= cmd_beats;
         max_len  <= cfg_max_len;
      end else if (ok_acc) begin
         cur_addr <= cur_addr + {22'b0, burst_beats5, 5'b0};
         remain   <= remain - burst_beats;
      end
   end

   // Outstanding counter, sticky underflow flag and completion pulse.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         outstanding   <= '0;
         err_underflow <= 1'b0;
         cmd_done      <= 1'b0;
      end else begin
         outstanding <= out_nxt;
         if (underflow) begin
            err_underflow <= 1'b1;
         end
         cmd_done <= (state == S_DRAIN) && (out_nxt == '0);
      end
   end

endmodule
